// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU codes and state encoding shared by the control
// sequencer, its wait counter and the datapath benches.
package cpu_ctrl_pkg;

  localparam int unsigned OpcodeW = 5;
  localparam int unsigned AluW    = 5;

  // ALU operation codes
  localparam logic [AluW-1:0] AluAdd = 5'b00001;
  localparam logic [AluW-1:0] AluAnd = 5'b00101;
  localparam logic [AluW-1:0] AluOr  = 5'b00110;

  // Instruction opcodes, IR[31:27]
  localparam logic [OpcodeW-1:0] OpLd   = 5'b00000;
  localparam logic [OpcodeW-1:0] OpLdi  = 5'b00001;
  localparam logic [OpcodeW-1:0] OpSt   = 5'b00010;
  localparam logic [OpcodeW-1:0] OpAddi = 5'b01100;
  localparam logic [OpcodeW-1:0] OpAndi = 5'b01101;
  localparam logic [OpcodeW-1:0] OpOri  = 5'b01110;
  localparam logic [OpcodeW-1:0] OpBr   = 5'b10011;
  localparam logic [OpcodeW-1:0] OpJr   = 5'b10100;
  localparam logic [OpcodeW-1:0] OpJal  = 5'b10101;
  localparam logic [OpcodeW-1:0] OpNop  = 5'b11010;
  localparam logic [OpcodeW-1:0] OpHalt = 5'b11011;

  // Encodings are visible on present_state, so they are fixed explicitly.
  typedef enum logic [4:0] {
    StRst  = 5'd0,
    StT0   = 5'd1,
    StT1   = 5'd2,
    StT2   = 5'd3,
    StT3   = 5'd4,
    StT4   = 5'd5,
    StT5   = 5'd6,
    StT6   = 5'd7,
    StT7   = 5'd8,
    StHalt = 5'd9,
    StIdle = 5'd10
  } state_e;

  function automatic logic op_is_defined(input logic [OpcodeW-1:0] op);
    return (op == OpLd)   || (op == OpLdi)  || (op == OpSt)  || (op == OpAddi) ||
           (op == OpAndi) || (op == OpOri)  || (op == OpBr)  || (op == OpJr)   ||
           (op == OpJal)  || (op == OpNop)  || (op == OpHalt);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: reloads on every step change, counts down while a step is
// held; done_o tells a memory step it has been held long enough.
module mem_wait_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load on entry, otherwise decrement and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore T-step control unit. Fetch T0-T2, opcode-dependent
// execute T3-T7, memory steps stretched by MEM_WAIT; halt or an undefined opcode
// parks the machine until reset.
// Optional build macro CTRL_SINGLE_STEP_EN: T0 is entered from an idle state
// only when step is high.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned      OPCODE_W = OpcodeW,
  parameter int unsigned      ALU_W    = AluW,
  parameter int unsigned      MEM_WAIT = 0,
  parameter logic [ALU_W-1:0] ALU_ADD  = AluAdd,
  parameter logic [ALU_W-1:0] ALU_AND  = AluAnd,
  parameter logic [ALU_W-1:0] ALU_OR   = AluOr
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                con_output,
  input  logic                step,
  output logic                PC_select,
  output logic                MDR_select,
  output logic                Z_LO_select,
  output logic                c_select,
  output logic                r_select,
  output logic                PC_enable,
  output logic                PC_increment_enable,
  output logic                IR_enable,
  output logic                Y_enable,
  output logic                Z_enable,
  output logic                MAR_enable,
  output logic                MDR_enable,
  output logic                r_enable,
  output logic                con_enable,
  output logic                manual_R15_enable,
  output logic                read,
  output logic                write,
  output logic                Gra,
  output logic                Grb,
  output logic                BAout,
  output logic [ALU_W-1:0]    alu_instruction,
  output logic                run,
  output logic                illegal,
  output logic [4:0]          present_state
);

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_e StNext = StIdle;
`else
  localparam state_e StNext = StT0;
  logic unused_step;
  assign unused_step = step;
`endif

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                illegal_q, illegal_d;
  logic                wait_done;

  logic is_ld, is_st, is_imm, is_jal, is_jr, is_br, is_nop;
  assign is_ld  = (op_q == OpLd);
  assign is_st  = (op_q == OpSt);
  assign is_imm = (op_q == OpLdi) || (op_q == OpAddi) || (op_q == OpAndi) || (op_q == OpOri);
  assign is_jal = (op_q == OpJal);
  assign is_jr  = (op_q == OpJr);
  assign is_br  = (op_q == OpBr);
  assign is_nop = (op_q == OpNop);

  mem_wait_counter #(
    .Width (4)
  ) u_wait (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (state_d != state_q),
    .load_val_i (4'(MEM_WAIT)),
    .done_o     (wait_done)
  );

  // Next-state sequencing; memory steps hold until the wait counter expires.
  always_comb begin
    state_d   = state_q;
    op_d      = (state_q == StT2) ? ir_opcode : op_q;
    illegal_d = illegal_q | ((state_q == StT3) && !op_is_defined(op_q));
    case (state_q)
      StRst: state_d = StNext;
      StT0:  state_d = StT1;
      StT1:  if (wait_done) state_d = StT2;
      StT2:  state_d = StT3;
      StT3: begin
        if (is_imm || is_ld || is_st || is_jal || is_br) state_d = StT4;
        else if (is_jr || is_nop)                        state_d = StNext;
        else                                             state_d = StHalt;
      end
      StT4:  state_d = is_jal ? StNext : StT5;
      StT5:  state_d = is_imm ? StNext : StT6;
      StT6: begin
        if (is_br)                   state_d = StNext;
        else if (is_st || wait_done) state_d = StT7;
      end
      StT7:  if (is_ld || wait_done) state_d = StNext;
      StHalt: state_d = StHalt;
`ifdef CTRL_SINGLE_STEP_EN
      StIdle: if (step) state_d = StT0;
`endif
      default: state_d = StRst;
    endcase
  end

  // State, latched opcode and sticky illegal flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRst;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode from the registered step and opcode.
  always_comb begin
    PC_select           = 1'b0;
    MDR_select          = 1'b0;
    Z_LO_select         = 1'b0;
    c_select            = 1'b0;
    r_select            = 1'b0;
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    r_enable            = 1'b0;
    con_enable          = 1'b0;
    manual_R15_enable   = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    BAout               = 1'b0;
    alu_instruction     = '0;
    run                 = (state_q != StRst) && (state_q != StHalt);
    case (state_q)
      StT0: begin
        PC_select  = 1'b1;
        MAR_enable = 1'b1;
      end
      StT1: begin
        read                = 1'b1;
        MDR_enable          = 1'b1;
        PC_increment_enable = wait_done;
      end
      StT2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end
      StT3: begin
        if (is_imm || is_ld || is_st) begin
          Grb      = 1'b1;
          BAout    = 1'b1;
          Y_enable = 1'b1;
        end else if (is_jal) begin
          manual_R15_enable = 1'b1;
          PC_select         = 1'b1;
        end else if (is_jr || is_br) begin
          Gra        = 1'b1;
          r_select   = 1'b1;
          PC_enable  = is_jr;
          con_enable = is_br;
        end
      end
      StT4: begin
        if (is_jal) begin
          Gra       = 1'b1;
          r_select  = 1'b1;
          PC_enable = 1'b1;
        end else if (is_br) begin
          PC_select = 1'b1;
          Y_enable  = 1'b1;
        end else begin
          c_select = 1'b1;
          Z_enable = 1'b1;
          if (op_q == OpAndi)     alu_instruction = ALU_AND;
          else if (op_q == OpOri) alu_instruction = ALU_OR;
          else                    alu_instruction = ALU_ADD;
        end
      end
      StT5: begin
        if (is_br) begin
          c_select        = 1'b1;
          Z_enable        = 1'b1;
          alu_instruction = ALU_ADD;
        end else begin
          Z_LO_select = 1'b1;
          Gra         = is_imm;
          r_enable    = is_imm;
          MAR_enable  = !is_imm;
        end
      end
      StT6: begin
        if (is_br) begin
          Z_LO_select = 1'b1;
          PC_enable   = con_output;
        end else begin
          MDR_enable = 1'b1;
          read       = is_ld;
          Gra        = is_st;
          r_select   = is_st;
        end
      end
      StT7: begin
        write      = is_st;
        MDR_select = is_ld;
        Gra        = is_ld;
        r_enable   = is_ld;
      end
      default: ;
    endcase
  end

  assign illegal       = illegal_q;
  assign present_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction stream against a step-table model;
// expected per-cycle output words are queued by the driver and checked by a
// forked monitor.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam int unsigned W = 2;

  localparam logic [4:0] S_T0 = 5'd1, S_T1 = 5'd2, S_T2 = 5'd3, S_T3 = 5'd4, S_T4 = 5'd5;
  localparam logic [4:0] S_T5 = 5'd6, S_T6 = 5'd7, S_T7 = 5'd8, S_HALT = 5'd9, S_IDLE = 5'd10;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110;
  localparam logic [4:0] OP_BR = 5'b10011, OP_JR = 5'b10100, OP_JAL = 5'b10101;
  localparam logic [4:0] OP_NOP = 5'b11010, OP_HALT = 5'b11011;
  localparam logic [4:0] A_ADD = 5'b00001, A_AND = 5'b00101, A_OR = 5'b00110;

  localparam int B_PCS = 0, B_MDRS = 1, B_ZLOS = 2, B_CS = 3, B_RS = 4, B_PCE = 5, B_PCI = 6;
  localparam int B_IRE = 7, B_YE = 8, B_ZE = 9, B_MARE = 10, B_MDRE = 11, B_RE = 12;
  localparam int B_CONE = 13, B_R15 = 14, B_RD = 15, B_WR = 16, B_GRA = 17, B_GRB = 18;
  localparam int B_BA = 19, B_RUN = 20, B_ILL = 21;

  logic clk = 1'b0;
  logic reset_n, con_output, step;
  logic [4:0] ir_opcode;
  logic PC_select, MDR_select, Z_LO_select, c_select, r_select;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable;
  logic MDR_enable, r_enable, con_enable, manual_R15_enable, read, write, Gra, Grb, BAout;
  logic run, illegal;
  logic [4:0] alu_instruction, present_state;

  always #5 clk = ~clk;

  control_sequencer #(
    .MEM_WAIT (W)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .ir_opcode           (ir_opcode),
    .con_output          (con_output),
    .step                (step),
    .PC_select           (PC_select),
    .MDR_select          (MDR_select),
    .Z_LO_select         (Z_LO_select),
    .c_select            (c_select),
    .r_select            (r_select),
    .PC_enable           (PC_enable),
    .PC_increment_enable (PC_increment_enable),
    .IR_enable           (IR_enable),
    .Y_enable            (Y_enable),
    .Z_enable            (Z_enable),
    .MAR_enable          (MAR_enable),
    .MDR_enable          (MDR_enable),
    .r_enable            (r_enable),
    .con_enable          (con_enable),
    .manual_R15_enable   (manual_R15_enable),
    .read                (read),
    .write               (write),
    .Gra                 (Gra),
    .Grb                 (Grb),
    .BAout               (BAout),
    .alu_instruction     (alu_instruction),
    .run                 (run),
    .illegal             (illegal),
    .present_state       (present_state)
  );

  logic [21:0] act_flags;
  logic [31:0] act;
  assign act_flags = {illegal, run, BAout, Grb, Gra, write, read, manual_R15_enable, con_enable,
                      r_enable, MDR_enable, MAR_enable, Z_enable, Y_enable, IR_enable,
                      PC_increment_enable, PC_enable, r_select, c_select, Z_LO_select,
                      MDR_select, PC_select};
  assign act = {present_state, alu_instruction, act_flags};

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int lat_cnt;
  int cyc_idx  = 0;
  logic ill_m  = 1'b0;

  function automatic logic [21:0] m(input int b);
    logic [21:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic push(input logic [4:0] st, input logic [21:0] f, input logic [4:0] alu,
                      input int n);
    logic [21:0] ff;
    for (int i = 0; i < n; i++) begin
      ff = f;
      ff[B_RUN] = (st != S_HALT);
      ff[B_ILL] = ill_m;
      exp_q.push_back({st, alu, ff});
      lat_cnt++;
    end
  endtask

  // Expected per-cycle trace of one instruction, straight from the step tables.
  task automatic push_instr(input logic [4:0] op, input logic con);
    logic defined;
    logic [4:0] alu;
    defined = op inside {OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JR,
                         OP_JAL, OP_NOP, OP_HALT};
    lat_cnt = 0;
`ifdef CTRL_SINGLE_STEP_EN
    push(S_IDLE, '0, '0, 1);
`endif
    push(S_T0, m(B_PCS) | m(B_MARE), '0, 1);
    for (int i = 0; i <= int'(W); i++)
      push(S_T1, m(B_RD) | m(B_MDRE) | ((i == int'(W)) ? m(B_PCI) : '0), '0, 1);
    push(S_T2, m(B_MDRS) | m(B_IRE), '0, 1);
    alu = (op == OP_ANDI) ? A_AND : (op == OP_ORI) ? A_OR : A_ADD;
    if (op inside {OP_LD, OP_ST, OP_LDI, OP_ADDI, OP_ANDI, OP_ORI}) begin
      push(S_T3, m(B_GRB) | m(B_BA) | m(B_YE), '0, 1);
      push(S_T4, m(B_CS) | m(B_ZE), alu, 1);
      if (op == OP_LD) begin
        push(S_T5, m(B_ZLOS) | m(B_MARE), '0, 1);
        push(S_T6, m(B_RD) | m(B_MDRE), '0, W + 1);
        push(S_T7, m(B_MDRS) | m(B_GRA) | m(B_RE), '0, 1);
      end else if (op == OP_ST) begin
        push(S_T5, m(B_ZLOS) | m(B_MARE), '0, 1);
        push(S_T6, m(B_GRA) | m(B_RS) | m(B_MDRE), '0, 1);
        push(S_T7, m(B_WR), '0, W + 1);
      end else begin
        push(S_T5, m(B_ZLOS) | m(B_GRA) | m(B_RE), '0, 1);
      end
    end else if (op == OP_JAL) begin
      push(S_T3, m(B_R15) | m(B_PCS), '0, 1);
      push(S_T4, m(B_GRA) | m(B_RS) | m(B_PCE), '0, 1);
    end else if (op == OP_JR) begin
      push(S_T3, m(B_GRA) | m(B_RS) | m(B_PCE), '0, 1);
    end else if (op == OP_BR) begin
      push(S_T3, m(B_GRA) | m(B_RS) | m(B_CONE), '0, 1);
      push(S_T4, m(B_PCS) | m(B_YE), '0, 1);
      push(S_T5, m(B_CS) | m(B_ZE), A_ADD, 1);
      push(S_T6, m(B_ZLOS) | (con ? m(B_PCE) : '0), '0, 1);
    end else if (op == OP_NOP) begin
      push(S_T3, '0, '0, 1);
    end else begin
      push(S_T3, '0, '0, 1);
      ill_m = !defined;
      push(S_HALT, '0, '0, 20);
    end
  endtask

  task automatic run_instr(input logic [4:0] op, input logic con);
    int lat;
    ir_opcode = op;
    push_instr(op, con);
    lat = lat_cnt;
    @(posedge clk);
    #2 con_output = con;
    repeat (lat) @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL cycle_%0d: got state=%0d alu=%b flags=%b, want state=%0d alu=%b flags=%b",
                      cyc_idx, act[31:27], act[26:22], act[21:0], e[31:27], e[26:22], e[21:0]);
        cyc_idx++;
      end
    end
  endtask

  logic [4:0] legal_ops[10];

  initial begin
    legal_ops = '{OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JR, OP_JAL, OP_NOP};
    reset_n    = 1'b0;
    ir_opcode  = '0;
    con_output = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b1;
`else
    step = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_now("reset_state", act, 32'h0);
    fork
      monitor();
    join_none
    reset_n = 1'b1;

    run_instr(OP_LDI, 1'b0);
    run_instr(OP_LD, 1'b0);
    run_instr(OP_JAL, 1'b0);
    run_instr(OP_BR, 1'b1);
    run_instr(OP_BR, 1'b0);
    run_instr(OP_ST, 1'b1);
    run_instr(OP_JR, 1'b0);
    run_instr(OP_NOP, 1'b1);
    run_instr(OP_ADDI, 1'b0);
    run_instr(OP_ANDI, 1'b1);
    run_instr(OP_ORI, 1'b0);
    for (int i = 0; i < 40; i++)
      run_instr(legal_ops[$urandom_range(9)], 1'($urandom_range(1)));
    run_instr(5'b11111, 1'b0);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    // Asynchronous reset out of HALT clears illegal without a clock edge.
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_now("async_reset_halt", act, 32'h0);

    // Reset in the middle of a stretched fetch read drops the strobe at once.
    @(negedge clk);
    reset_n   = 1'b1;
    ir_opcode = OP_LD;
    @(posedge clk);
`ifdef CTRL_SINGLE_STEP_EN
    @(posedge clk);
`endif
    @(posedge clk);
    #2 check_now("t1_strobe_first", 32'({read, MDR_enable, PC_increment_enable}), 32'b110);
    @(posedge clk);
    #2 check_now("t1_strobe_held", 32'({read, MDR_enable, PC_increment_enable}), 32'b110);
    reset_n = 1'b0;
    #1 check_now("async_reset_strobe", act, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
